align_shift_pipe: RTL and testbench
===================================

Name: align_shift_pipe

Overview:
Pipelined, parametrised addend alignment shifter for the multi-precision FMA datapath. It aligns up to four packed addend lanes against the product, each lane with its own shift amount. It generates a per-lane sticky bit and a shift-saturation flag. Sits between operand unpack and the product/addend adder, with a valid/ready handshake on both sides.

Parameters:
W, 53, full-width mantissa (single-lane width).
SH_W, 8, width of each lane shift amount.
Derived (not overridable): H = floor(W/2), dual-lane width; Q = floor(W/4), quad-lane width.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat this cycle
mode  input  2  00 single, 01 quad, 10 dual, 11 illegal
in  input  W  packed addend mantissas; lane k at [k*L +: L]
shamt  input  4*SH_W  lane k shift amount at [k*SH_W +: SH_W]; single uses lane 0
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts output
out_shifted  output  2*W  aligned lanes; lane k at [k*2L +: 2L]
out_sticky  output  4  per-lane OR of bits shifted below the field
out_sat  output  4  per-lane shamt >= 2L
out_illegal  output  1  beat carried mode 11

Behaviour:
- Lane width L: W in single mode (1 lane), H in dual mode (2 lanes), Q in quad mode (4 lanes).
- In input bits above the last lane are ignored.
- Mode 11 is processed as single mode with out_illegal=1.
- Per lane: field F = {lane, L zeros}, width 2L; s = min(shamt_k, 2L).
  - Result = F >> s, logical shift.
  - out_sticky[k] = OR of the F bits at positions < s.
  - out_sat[k] = (shamt_k >= 2L).
  - For s = 2L: result is 0 and sticky = |lane.
- Unused lanes: out_sticky, out_sat and their out_shifted positions are 0. Any out_shifted bits above the last lane are 0.
- Pipeline has two register stages:
  - S1 captures mode, in and the saturated shift amounts, then performs the shifts.
  - S2 holds shifted, sticky, sat and illegal.
  - Latency from an accepted input to out_valid is 2 cycles when out_ready stays high. Throughput is 1 beat per cycle.
- Handshake:
  - Input is accepted when in_valid && in_ready.
  - Output is consumed when out_valid && out_ready.
  - S2 loads when it is empty or being consumed. S1 advances into S2 under the same condition.
  - in_ready = !S1_valid || S2 will load this cycle (combinational from out_ready). No beat is ever dropped or duplicated.
  - While out_valid && !out_ready, all out_* signals hold stable.
- Reset (asynchronous, any time including mid-transfer):
  - out_valid=0, both stage valids=0.
  - out_shifted=0, out_sticky=0, out_sat=0, out_illegal=0.
  - in_ready=1 from the first cycle after rst_n deasserts.
  - In-flight beats are discarded.
- Simultaneous accept and consume with both stages full: the pipeline shifts by one and holds 2 beats.
- shamt wider than 2L saturates; there is no wrap-around.
- Datapath registers only load on an advance.

Test Plan:
- Single mode, in=1<<52, shamt0=0 -> out_shifted=1<<105, sticky=0, sat=0; with shamt0=60 -> bit 45 set only, sticky=0.
- Single mode, in=1<<52 | 1, shamt0=110 -> out_shifted=0, out_sticky[0]=1, out_sat[0]=1. With shamt0=54 -> bit 51 set, sticky[0]=1.
- Quad mode, lane0=13'h1001, shamt0=14, other lanes 0 with shamt 0 -> out_shifted[25:0]=26'h800, sticky=4'b0001. Lanes 1-3 zero, sticky 0.
- Dual mode, lane1=26'h2000001, shamt1=26 -> out_shifted[103:52]=52'h2000001 (lane1's own 52-bit field shifted down by 26), sticky[1]=0. out_shifted[105:104]=0.
- Backpressure: stream 5 beats with out_ready=0 for 4 cycles -> in_ready drops after 2 accepts and outputs hold stable. On release, all 5 beats emerge in order, none duplicated.
- Mode 11 beat -> same data as mode 00, out_illegal=1. Assert rst_n=0 mid-stream -> out_valid=0 and all outputs 0 immediately; no pre-reset beat appears after release.

Source files
------------

// File: rtl/align_shift_pipe.sv
// align_shift_pipe: two-stage addend alignment shifter for the FMA datapath.
// Up to four packed lanes, each with its own shift, sticky bit and saturation flag.
`default_nettype none

module align_shift_pipe #(
  parameter int W    = 53,
  parameter int SH_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [W-1:0]      in,
  input  logic [4*SH_W-1:0] shamt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*W-1:0]    out_shifted,
  output logic [3:0]        out_sticky,
  output logic [3:0]        out_sat,
  output logic              out_illegal
);

  localparam int H  = W / 2;
  localparam int Q  = W / 4;
  localparam int WF = 2 * W;
  localparam int HF = 2 * H;
  localparam int QF = 2 * Q;
  localparam int SW = $clog2(2 * W + 1);
  localparam int CW = (SH_W > SW) ? SH_W : SW;

  localparam logic [1:0] MODE_QUAD = 2'b01;
  localparam logic [1:0] MODE_DUAL = 2'b10;
  localparam logic [1:0] MODE_ILL  = 2'b11;

  logic [CW-1:0] w_lim;
  logic [CW-1:0] w_sh_ext [4];
  logic [SW-1:0] w_s      [4];
  logic          w_s2_load;
  logic          w_accept;

  logic          r_s1_valid;
  logic [1:0]    r_s1_mode;
  logic [W-1:0]  r_s1_in;
  logic [SW-1:0] r_s1_s   [4];

  logic [WF-1:0] w_shifted;
  logic [3:0]    w_sticky;
  logic [3:0]    w_sat;

  logic          r_s2_valid;
  logic [WF-1:0] r_shifted;
  logic [3:0]    r_sticky;
  logic [3:0]    r_sat;
  logic          r_ill;

  // Field width 2L depends on the lane split; it is both the clamp value and the sat threshold.
  always_comb begin
    case (mode)
      MODE_QUAD: w_lim = CW'(QF);
      MODE_DUAL: w_lim = CW'(HF);
      default:   w_lim = CW'(WF);
    endcase
  end

  for (genvar k = 0; k < 4; k++) begin : g_clamp
    assign w_sh_ext[k] = CW'(shamt[k*SH_W +: SH_W]);
    assign w_s[k]      = (w_sh_ext[k] >= w_lim) ? w_lim[SW-1:0] : w_sh_ext[k][SW-1:0];
  end

  assign w_s2_load = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_load;
  assign w_accept  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 2'b00;
      r_s1_in    <= '0;
      r_s1_s     <= '{default: '0};
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_mode  <= mode;
        r_s1_in    <= in;
        r_s1_s     <= w_s;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  // Sticky masks the field bits below the clamped shift; a shift of 2L leaves an all-ones mask.
  always_comb begin
    w_shifted = '0;
    w_sticky  = '0;
    w_sat     = '0;
    case (r_s1_mode)
      MODE_QUAD: begin
        for (int k = 0; k < 4; k++) begin
          w_shifted[k*QF +: QF] = {r_s1_in[k*Q +: Q], {Q{1'b0}}} >> r_s1_s[k];
          w_sticky[k] = |({r_s1_in[k*Q +: Q], {Q{1'b0}}} & ~({QF{1'b1}} << r_s1_s[k]));
          w_sat[k]    = (r_s1_s[k] == SW'(QF));
        end
      end
      MODE_DUAL: begin
        for (int k = 0; k < 2; k++) begin
          w_shifted[k*HF +: HF] = {r_s1_in[k*H +: H], {H{1'b0}}} >> r_s1_s[k];
          w_sticky[k] = |({r_s1_in[k*H +: H], {H{1'b0}}} & ~({HF{1'b1}} << r_s1_s[k]));
          w_sat[k]    = (r_s1_s[k] == SW'(HF));
        end
      end
      default: begin
        w_shifted   = {r_s1_in, {W{1'b0}}} >> r_s1_s[0];
        w_sticky[0] = |({r_s1_in, {W{1'b0}}} & ~({WF{1'b1}} << r_s1_s[0]));
        w_sat[0]    = (r_s1_s[0] == SW'(WF));
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_shifted  <= '0;
      r_sticky   <= '0;
      r_sat      <= '0;
      r_ill      <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_shifted <= w_shifted;
        r_sticky  <= w_sticky;
        r_sat     <= w_sat;
        r_ill     <= (r_s1_mode == MODE_ILL);
      end
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_shifted = r_shifted;
  assign out_sticky  = r_sticky;
  assign out_sat     = r_sat;
  assign out_illegal = r_ill;

endmodule

`default_nettype wire

// File: tb/tb_align_shift_pipe.sv
// Testbench for align_shift_pipe: table of hand-derived vectors fed through a scoreboard,
// plus backpressure and mid-stream reset sequences.
`default_nettype none

module tb_align_shift_pipe;

  typedef struct {
    int           id;
    logic [1:0]   mode;
    logic [52:0]  din;
    logic [31:0]  sh;
    logic [105:0] shifted;
    logic [3:0]   sticky;
    logic [3:0]   sat;
    logic         ill;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   mode;
  logic [52:0]  din;
  logic [31:0]  shamt;
  logic         out_valid;
  logic         out_ready;
  logic [105:0] out_shifted;
  logic [3:0]   out_sticky;
  logic [3:0]   out_sat;
  logic         out_illegal;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_acc   = 0;
  vec_t sb[$];
  vec_t tbl[12];

  align_shift_pipe #(.W(53), .SH_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .in(din), .shamt(shamt), .out_valid(out_valid),
    .out_ready(out_ready), .out_shifted(out_shifted), .out_sticky(out_sticky),
    .out_sat(out_sat), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int id, input logic [1:0] m, input logic [52:0] d,
                              input logic [31:0] s, input logic [105:0] r,
                              input logic [3:0] st, input logic [3:0] sa, input logic il);
    vec_t v;
    v.id = id; v.mode = m; v.din = d; v.sh = s;
    v.shifted = r; v.sticky = st; v.sat = sa; v.ill = il;
    return v;
  endfunction

  task automatic send(input vec_t v);
    int g;
    g = 0;
    @(negedge clk);
    in_valid = 1'b1;
    mode     = v.mode;
    din      = v.din;
    shamt    = v.sh;
    #1;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: beat %0d never accepted", v.id);
      in_valid = 1'b0;
    end else begin
      sb.push_back(v);
      n_acc++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("drain_remaining", 128'(sb.size()), 128'd0);
  endtask

  // Output monitor: pops the scoreboard on each consumed beat and checks stall stability.
  logic [115:0] held;
  bit           stalled = 0;
  always begin
    vec_t e;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      stalled = 0;
    end else begin
      if (stalled)
        chk("hold_stable", {out_valid, out_shifted, out_sticky, out_sat, out_illegal}, held);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got shifted 0x%0h, expected no beat", out_shifted);
        end else begin
          e = sb.pop_front();
          chk($sformatf("beat%0d_shifted", e.id), out_shifted, e.shifted);
          chk($sformatf("beat%0d_sticky", e.id), out_sticky, e.sticky);
          chk($sformatf("beat%0d_sat", e.id), out_sat, e.sat);
          chk($sformatf("beat%0d_illegal", e.id), out_illegal, e.ill);
        end
        stalled = 0;
      end else if (out_valid) begin
        stalled = 1;
        held = {out_valid, out_shifted, out_sticky, out_sat, out_illegal};
      end else begin
        stalled = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; mode = 2'b00; din = '0; shamt = '0; out_ready = 1'b1;

    tbl[0]  = mk(0,  2'b00, 53'd1 << 52, {8'd200, 8'd7, 8'd3, 8'd0}, 106'd1 << 105, 4'b0000, 4'b0000, 1'b0);
    tbl[1]  = mk(1,  2'b00, 53'd1 << 52, 32'd60, 106'd1 << 45, 4'b0000, 4'b0000, 1'b0);
    tbl[2]  = mk(2,  2'b00, (53'd1 << 52) | 53'd1, 32'd110, 106'd0, 4'b0001, 4'b0001, 1'b0);
    tbl[3]  = mk(3,  2'b00, (53'd1 << 52) | 53'd1, 32'd54, 106'd1 << 51, 4'b0001, 4'b0000, 1'b0);
    tbl[4]  = mk(4,  2'b01, 53'h1001, 32'd14, 106'h800, 4'b0001, 4'b0000, 1'b0);
    tbl[5]  = mk(5,  2'b10, (53'h2000001 << 26) | (53'd1 << 52), {8'd9, 8'd9, 8'd26, 8'd0},
                 106'h2000001 << 52, 4'b0000, 4'b0000, 1'b0);
    tbl[6]  = mk(6,  2'b11, (53'd1 << 52) | 53'd1, 32'd54, 106'd1 << 51, 4'b0001, 4'b0000, 1'b1);
    tbl[7]  = mk(7,  2'b10, (53'h3 << 26) | 53'h1, {16'd0, 8'd51, 8'd52}, 106'd0, 4'b0011, 4'b0001, 1'b0);
    tbl[8]  = mk(8,  2'b01, (53'd1 << 52) | (53'd3 << 39) | (53'h1000 << 26) | (53'd1 << 13) | 53'h1FFF,
                 {8'd255, 8'd0, 8'd13, 8'd26}, (106'd1 << 26) | (106'd1 << 77), 4'b1001, 4'b1001, 1'b0);
    tbl[9]  = mk(9,  2'b00, 53'd0, 32'd255, 106'd0, 4'b0000, 4'b0001, 1'b0);
    tbl[10] = mk(10, 2'b00, 53'd1 << 52, 32'd105, 106'd1, 4'b0000, 4'b0000, 1'b0);
    tbl[11] = mk(11, 2'b00, 53'd1 << 52, 32'd106, 106'd0, 4'b0001, 4'b0001, 1'b0);

    repeat (3) @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_outputs", {out_shifted, out_sticky, out_sat, out_illegal}, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("in_ready_after_reset", in_ready, 1'b1);

    for (int i = 0; i < 12; i++) send(tbl[i]);
    drain();

    // Backpressure: two accepts fill both stages, then the third beat must wait.
    @(negedge clk);
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(tbl[i]);
      end
      begin
        repeat (4) @(negedge clk);
        #3;
        chk("bp_accepts_while_stalled", 128'(n_acc), 128'd2);
        chk("bp_in_ready_low", in_ready, 1'b0);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_total_accepts", 128'(n_acc), 128'd5);

    // Asynchronous reset with both stages holding beats.
    out_ready = 1'b0;
    send(tbl[7]);
    send(tbl[8]);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", out_valid, 1'b0);
    chk("midreset_outputs", {out_shifted, out_sticky, out_sat, out_illegal}, 128'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("midreset_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("no_stale_beat", out_valid, 1'b0);
    end
    send(tbl[3]);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
